// File: rtl/img_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | img_pkg : shared widths, colour key default and clog2 helper             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package img_pkg;

  localparam int CLR_W = 12;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  localparam logic [CLR_W-1:0] KEY_CLR_DEF = 12'h000;

  function automatic int clog2(input longint value);
    int w;
    w = 0;
    for (int i = 0; i < 62; i++) begin
      if ((longint'(1) << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/img_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | img_delay_line : DEPTH-stage shift register with async active-low clear  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module img_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else begin
      r_sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign q = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/img_sprite_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | img_sprite_fetch : maps screen (x,y) onto a block-ROM image with origin, |
// | integer scaling and mirroring; aligns colour/hit with the ROM output.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module img_sprite_fetch
  import img_pkg::*;
#(
  parameter int               IMG_W      = 320,
  parameter int               IMG_H      = 240,
  parameter int               CLR_W      = img_pkg::CLR_W,
  parameter int               ROM_LAT    = 1,
  parameter int               SCALE_LOG2 = 0,
  parameter logic [CLR_W-1:0] KEY_CLR    = KEY_CLR_DEF,
  localparam int              ADDR_W     = clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic              pix_valid,
  input  logic              frame_start,
  input  logic [X_W-1:0]    org_x,
  input  logic [Y_W-1:0]    org_y,
  input  logic              mirror,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CLR_W-1:0]  rom_data,
  output logic [CLR_W-1:0]  clr,
  output logic              clr_valid,
  output logic              hit
);

  localparam int REL_W     = X_W + 1;
  localparam int c_span_x  = IMG_W << SCALE_LOG2;
  localparam int c_span_y  = IMG_H << SCALE_LOG2;

  // Per-frame shadows
  logic [X_W-1:0] r_org_x;
  logic [Y_W-1:0] r_org_y;
  logic           r_mirror;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_org_x  <= '0;
      r_org_y  <= '0;
      r_mirror <= 1'b0;
    end else if (frame_start) begin
      r_org_x  <= org_x;
      r_org_y  <= org_y;
      r_mirror <= mirror;
    end
  end

  // Zero-extended subtraction; the top bit is the sign of the relative offset
  logic [REL_W-1:0] w_rel_x;
  logic [REL_W-1:0] w_rel_y;
  logic             w_inb;

  assign w_rel_x = {1'b0, x} - {1'b0, r_org_x};
  assign w_rel_y = {{(REL_W-Y_W){1'b0}}, y} - {{(REL_W-Y_W){1'b0}}, r_org_y};

  assign w_inb = !w_rel_x[REL_W-1] && (32'(w_rel_x[REL_W-2:0]) < c_span_x) &&
                 !w_rel_y[REL_W-1] && (32'(w_rel_y[REL_W-2:0]) < c_span_y);

  logic           r1_valid;
  logic           r1_inb;
  logic           r1_mirror;
  logic [X_W-1:0] r1_rel_x;
  logic [X_W-1:0] r1_rel_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r1_inb    <= 1'b0;
      r1_mirror <= 1'b0;
      r1_rel_x  <= '0;
      r1_rel_y  <= '0;
    end else begin
      r1_valid  <= pix_valid;
      r1_inb    <= w_inb;
      r1_mirror <= r_mirror;
      r1_rel_x  <= w_rel_x[X_W-1:0];
      r1_rel_y  <= w_rel_y[X_W-1:0];
    end
  end

  logic [X_W-1:0]    w_ix;
  logic [X_W-1:0]    w_iy;
  logic [X_W-1:0]    w_ix_sel;
  logic [ADDR_W-1:0] w_addr;

  assign w_ix     = r1_rel_x >> SCALE_LOG2;
  assign w_iy     = r1_rel_y >> SCALE_LOG2;
  assign w_ix_sel = r1_mirror ? (X_W'(IMG_W - 1) - w_ix) : w_ix;
  assign w_addr   = ADDR_W'(w_iy) * ADDR_W'(IMG_W) + ADDR_W'(w_ix_sel);

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r2_valid;
  logic              r2_inb;

  // Address only moves for visible in-bounds pixels to keep ROM inputs quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r2_valid   <= 1'b0;
      r2_inb     <= 1'b0;
    end else begin
      r2_valid <= r1_valid;
      r2_inb   <= r1_valid && r1_inb;
      if (r1_valid && r1_inb) begin
        r_rom_addr <= w_addr;
      end
    end
  end

  logic [1:0] w_dq;

  img_delay_line #(
    .WIDTH (2),
    .DEPTH (ROM_LAT)
  ) u_flag_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({r2_valid, r2_inb}),
    .q     (w_dq)
  );

  assign rom_addr  = r_rom_addr;
  assign clr_valid = w_dq[1];
  assign clr       = w_dq[0] ? rom_data : '0;
  assign hit       = w_dq[0] && (rom_data != KEY_CLR);

endmodule
`default_nettype wire

// File: tb/tb_img_sprite_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_img_sprite_fetch : two instances (defaults; scale x2 with 3-cycle ROM) |
// | against a per-pixel reference model. Rev 1.0                             |
// +--------------------------------------------------------------------------+
module tb_img_sprite_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic [9:0]  org_x = '0;
  logic [8:0]  org_y = '0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        mirror = 1'b0;

  logic [16:0] rom_addr_a, rom_addr_b;
  logic [11:0] rom_data_a, rom_data_b, clr_a, clr_b;
  logic        clr_valid_a, clr_valid_b, hit_a, hit_b;
  logic [16:0] b_p1, b_p2;

  logic [11:0] rom_mem [0:131071];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit in_rst = 1'b0;
  int sh_ox = 0;
  int sh_oy = 0;
  bit sh_m = 1'b0;
  int m_addr_a = 0;
  int m_addr_b = 0;

  bit h_v     [0:4095];
  bit h_inb_a [0:4095];
  bit h_inb_b [0:4095];
  int h_addr_a [0:4095];
  int h_addr_b [0:4095];

  always #5 clk = ~clk;

  img_sprite_fetch dut_a (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pix_valid(pix_valid),
    .frame_start(frame_start), .org_x(org_x), .org_y(org_y), .mirror(mirror),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .clr(clr_a),
    .clr_valid(clr_valid_a), .hit(hit_a)
  );

  img_sprite_fetch #(.ROM_LAT(3), .SCALE_LOG2(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pix_valid(pix_valid),
    .frame_start(frame_start), .org_x(org_x), .org_y(org_y), .mirror(mirror),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .clr(clr_b),
    .clr_valid(clr_valid_b), .hit(hit_b)
  );

  always @(posedge clk) begin
    rom_data_a <= rom_mem[rom_addr_a];
    b_p1       <= rom_addr_b;
    b_p2       <= b_p1;
    rom_data_b <= rom_mem[b_p2];
  end

  task automatic ref_px(input int xx, input int yy, input int ox, input int oy,
                        input bit m, input int sl, output bit inb, output int addr);
    int rx, ry, ix, iy;
    rx  = xx - ox;
    ry  = yy - oy;
    inb = (rx >= 0) && (rx < (320 << sl)) && (ry >= 0) && (ry < (240 << sl));
    ix  = inb ? (rx >> sl) : 0;
    iy  = inb ? (ry >> sl) : 0;
    if (m) ix = 319 - ix;
    addr = iy * 320 + ix;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int ia, ib, da, db;
    bit va, vb, ina, inb_b;
    chk("rom_addr_a", int'(rom_addr_a), m_addr_a);
    chk("rom_addr_b", int'(rom_addr_b), m_addr_b);
    ia = cyc - 3; va = 1'b0; ina = 1'b0; da = 0;
    if (ia >= 0) begin
      va  = h_v[ia];
      ina = va && h_inb_a[ia];
      if (ina) da = int'(rom_mem[h_addr_a[ia]]);
    end
    chk("clr_valid_a", int'(clr_valid_a), int'(va));
    chk("clr_a", int'(clr_a), da);
    chk("hit_a", int'(hit_a), int'(ina && (da != 0)));
    ib = cyc - 5; vb = 1'b0; inb_b = 1'b0; db = 0;
    if (ib >= 0) begin
      vb    = h_v[ib];
      inb_b = vb && h_inb_b[ib];
      if (inb_b) db = int'(rom_mem[h_addr_b[ib]]);
    end
    chk("clr_valid_b", int'(clr_valid_b), int'(vb));
    chk("clr_b", int'(clr_b), db);
    chk("hit_b", int'(hit_b), int'(inb_b && (db != 0)));
  endtask

  task automatic step(input bit v, input int xx, input int yy, input bit fs,
                      input int ox, input int oy, input bit m);
    bit ia, ib;
    int aa, ab;
    pix_valid   = v;
    x           = 10'(xx);
    y           = 9'(yy);
    frame_start = fs;
    org_x       = 10'(ox);
    org_y       = 9'(oy);
    mirror      = m;
    ref_px(xx, yy, sh_ox, sh_oy, sh_m, 0, ia, aa);
    ref_px(xx, yy, sh_ox, sh_oy, sh_m, 1, ib, ab);
    h_v[cyc]      = v && !in_rst;
    h_inb_a[cyc]  = ia;
    h_addr_a[cyc] = aa;
    h_inb_b[cyc]  = ib;
    h_addr_b[cyc] = ab;
    if (fs && !in_rst) begin
      sh_ox = ox; sh_oy = oy; sh_m = m;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= 2) begin
      if (h_v[cyc-2] && h_inb_a[cyc-2]) m_addr_a = h_addr_a[cyc-2];
      if (h_v[cyc-2] && h_inb_b[cyc-2]) m_addr_b = h_addr_b[cyc-2];
    end
    check_outputs();
  endtask

  task automatic do_reset(input int hold);
    rst_n  = 1'b0;
    in_rst = 1'b1;
    #1;
    chk("rst_rom_addr_a", int'(rom_addr_a), 0);
    chk("rst_rom_addr_b", int'(rom_addr_b), 0);
    chk("rst_clr_valid_a", int'(clr_valid_a), 0);
    chk("rst_clr_valid_b", int'(clr_valid_b), 0);
    chk("rst_clr_a", int'(clr_a), 0);
    chk("rst_clr_b", int'(clr_b), 0);
    chk("rst_hit_a", int'(hit_a), 0);
    chk("rst_hit_b", int'(hit_b), 0);
    for (int i = 0; i <= cyc; i++) h_v[i] = 1'b0;
    m_addr_a = 0; m_addr_b = 0;
    sh_ox = 0; sh_oy = 0; sh_m = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step(1'b1, $urandom_range(0, 1023), $urandom_range(0, 511), 1'b0, 0, 0, 1'b0);
    end
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  task automatic rnd_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 799), $urandom_range(0, 511),
           $urandom_range(0, 15) == 0, $urandom_range(0, 480), $urandom_range(0, 300),
           $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) rom_mem[i] = 12'($urandom_range(1, 4095));
    for (int i = 5; i < 131072; i += 13) rom_mem[i] = 12'h000;
    rom_mem[0]    = 12'hF00;
    rom_mem[321]  = 12'h000;
    rom_mem[319]  = 12'h0A5;
    rom_mem[641]  = 12'h123;
    rom_mem[3210] = 12'h456;

    #2;
    do_reset(3);

    // Origin (100,50): corner, far corner, diagonal neighbour (transparent)
    step(1'b0, 0, 0, 1'b1, 100, 50, 1'b0);
    step(1'b1, 100, 50, 1'b0, 0, 0, 1'b0);
    step(1'b1, 419, 289, 1'b0, 0, 0, 1'b0);
    chk("origin_addr", int'(rom_addr_a), 0);
    step(1'b1, 101, 51, 1'b0, 0, 0, 1'b0);
    chk("max_addr", int'(rom_addr_a), 76799);
    step(1'b1, 99, 50, 1'b0, 0, 0, 1'b0);
    chk("diag_addr", int'(rom_addr_a), 321);
    step(1'b1, 420, 50, 1'b0, 0, 0, 1'b0);
    chk("clip_left_hold", int'(rom_addr_a), 321);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    chk("clip_right_hold", int'(rom_addr_a), 321);

    step(1'b0, 0, 0, 1'b1, 100, 50, 1'b1);
    step(1'b1, 100, 50, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    chk("mirror_addr", int'(rom_addr_a), 319);

    step(1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
    step(1'b1, 3, 5, 1'b0, 0, 0, 1'b0);
    step(1'b1, 640, 0, 1'b0, 0, 0, 1'b0);
    chk("scale_addr", int'(rom_addr_b), 641);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    chk("scale_oob_hold", int'(rom_addr_b), 641);

    // Origin change in the same cycle as a pixel: that pixel sees the old origin
    step(1'b1, 10, 10, 1'b1, 10, 10, 1'b0);
    step(1'b1, 10, 10, 1'b0, 0, 0, 1'b0);
    chk("fs_old_origin", int'(rom_addr_a), 3210);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    chk("fs_new_origin", int'(rom_addr_a), 0);

    for (int i = 0; i < 10; i++) step(1'b1, 10 + i * 7, 12 + i, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) step(1'b1, 20 + i, 30, 1'b0, 0, 0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);

    rnd_steps(400);
    do_reset(1);
    rnd_steps(200);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/img_sprite_fetch.md
Name: img_sprite_fetch

Overview:
- Parametrised, pipelined image fetcher for the VGA path.
- Maps the current screen pixel (x, y) onto a block-ROM image placed at a per-frame origin, with optional integer scaling and horizontal mirroring.
- Aligns the ROM output with a valid/hit flag so the downstream layer mixer can compose menu, map and sprite layers.
- Sits between the VGA timing generator and the layer mixer; one instance per image layer.

Parameters:
- IMG_W, 320, image width in pixels; the ROM row stride.
- IMG_H, 240, image height in pixels.
- CLR_W, 12, colour width (RGB444).
- ROM_LAT, 1, ROM read latency in cycles (1..3).
- SCALE_LOG2, 0, pixel replication factor 2^SCALE_LOG2 (0..2).
- KEY_CLR, 12'h000, transparent colour key.
- ADDR_W, derived localparam, clog2(IMG_W*IMG_H); 17 at defaults.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- x  in  10  screen column
- y  in  9  screen row
- pix_valid  in  1  x/y valid this cycle (visible area)
- frame_start  in  1  one-cycle pulse; latches org_x/org_y/mirror
- org_x  in  10  image left edge, screen coordinates
- org_y  in  9  image top edge, screen coordinates
- mirror  in  1  horizontal flip request
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  CLR_W  ROM read data, ROM_LAT cycles after rom_addr
- clr  out  CLR_W  pixel colour
- clr_valid  out  1  clr corresponds to a valid input pixel
- hit  out  1  pixel is in-bounds and not KEY_CLR

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rom_addr, clr, clr_valid and hit go to 0.
  - Origin and mirror shadows go to 0.
  - All pipeline valid bits clear immediately.
  - After release, the first valid output requires a fresh pix_valid. Reset mid-stream drops in-flight pixels with no partial output.
- Shadow registers:
  - On frame_start=1, org_x, org_y and mirror load into shadows.
  - The new values apply from the next cycle. A pixel presented in the frame_start cycle uses the old shadows.
- S1 (cycle 1): register x, y and pix_valid.
  - Compute signed 11-bit rel_x = x - org_x and rel_y = y - org_y.
  - inb = rel_x >= 0 and rel_x < IMG_W<<SCALE_LOG2 and rel_y >= 0 and rel_y < IMG_H<<SCALE_LOG2.
- S2 (cycle 2): form the address.
  - ix = rel_x >> SCALE_LOG2; iy = rel_y >> SCALE_LOG2.
  - If mirror, ix = IMG_W-1-ix.
  - If valid and inb, rom_addr = iy*IMG_W + ix (exact product, truncated to ADDR_W). Otherwise rom_addr holds its previous value to save ROM toggles.
- Output stage (cycle 2+ROM_LAT):
  - clr_valid = delayed valid.
  - clr = rom_data if delayed inb, else 0.
  - hit = delayed inb and rom_data != KEY_CLR.
  - Total latency from pix_valid to clr_valid is 2+ROM_LAT, i.e. 3 at defaults. Throughput is one pixel per cycle with no bubbles.
- Boundaries:
  - The address maxes out at IMG_W*IMG_H-1 (76799 at defaults).
  - An image partially off-screen is clipped naturally. Origin arithmetic never wraps; negative rel values are out-of-bounds.
  - pix_valid=0 produces clr_valid=0 three cycles later; clr and hit are then 0.

Decomposition:
- Package img_pkg holds:
  - CLR_W and the screen coordinate widths (X_W=10, Y_W=9);
  - the default KEY_CLR;
  - a clog2 function used for ADDR_W.
- Sub-module img_delay_line: parametrised-depth, parametrised-width shift register with async active-low clear. It carries valid/inb through the ROM_LAT stages; depth ROM_LAT.

Test Plan:
- Reset: hold rst_n=0 with pix_valid=1 -> rom_addr=0, clr=0, clr_valid=0, hit=0. Assert rst_n=0 mid-stream -> clr_valid drops to 0 in the same cycle; no stale pixel appears after release.
- Origin/address, defaults:
  - frame_start with org=(100,50), then pix (100,50) -> rom_addr=0 at cycle 2; clr=rom_data, clr_valid=1, hit=1 at cycle 3.
  - pix (419,289) -> rom_addr=76799.
  - pix (101,51) -> rom_addr=321.
- Clipping: org=(100,50), pix (99,50) and pix (420,50) -> clr_valid=1, clr=0, hit=0, rom_addr unchanged from the previous in-bounds value.
- Mirror/scale:
  - mirror=1, pix (100,50) -> rom_addr=319.
  - SCALE_LOG2=1, org=(0,0), pix (3,5) -> rom_addr=2*320+1=641.
  - SCALE_LOG2=1, pix (640,0) -> out of bounds.
- Transparency: rom_data=12'h000 for an in-bounds pixel -> clr_valid=1, hit=0, clr=12'h000. rom_data=12'hF00 -> hit=1.
- Frame_start/latency:
  - frame_start with org=(10,10) in the same cycle as pix (10,10), old origin (0,0) -> rom_addr=3210.
  - The next pixel uses the new origin.
  - Repeat with ROM_LAT=3 -> clr_valid appears exactly 5 cycles after pix_valid, back-to-back pixels without gaps.
